// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcode encodings, command and result records.
package alu_seq_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_NOT = 3'b010;
    localparam logic [2:0] ALU_OP_AND = 3'b011;
    localparam logic [2:0] ALU_OP_OR  = 3'b100;
    localparam logic [2:0] ALU_OP_XOR = 3'b101;
    localparam logic [2:0] ALU_OP_LT  = 3'b110;
    localparam logic [2:0] ALU_OP_EQ  = 3'b111;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] y;
        logic       zf;
        logic       of;
        logic       cf;
    } res_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible combinationally while non-empty.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    cmd_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; the head is only consumed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds a 1-cycle registered ALU from a command FIFO and returns tagged results in order.
// Optional sticky overflow/carry flags are built when ALU_SEQ_STICKY_FLAGS_EN is defined.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RES_BUF = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [3:0]               cmd_a,
    input  logic [3:0]               cmd_b,
    output logic [2:0]               alu_sel,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    input  logic [3:0]               alu_y,
    input  logic                     alu_zf,
    input  logic                     alu_of,
    input  logic                     alu_cf,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2:0]               res_op,
    output logic [3:0]               res_y,
    output logic                     res_zf,
    output logic                     res_of,
    output logic                     res_cf,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    input  logic                     sticky_clr,
    output logic                     sticky_of,
    output logic                     sticky_cf
`endif
);

    cmd_t        push_data;
    cmd_t        head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        issue;
    logic        pop_res;
    logic        inflight;
    logic [2:0]  inflight_op;
    logic [1:0]  res_count;
    logic [1:0]  count_after_pop;
    logic [2:0]  occupancy;
    res_t        slot0;
    res_t        slot1;
    res_t        captured;

    assign push_data = '{op: cmd_op, a: cmd_a, b: cmd_b};

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid),
        .push_data (push_data),
        .pop       (issue),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign cmd_ready = !fifo_full;

    assign alu_sel = fifo_empty ? 3'd0 : head.op;
    assign alu_a   = fifo_empty ? 4'd0 : head.a;
    assign alu_b   = fifo_empty ? 4'd0 : head.b;

    assign res_valid = (res_count != 2'd0);
    assign pop_res   = res_valid && res_ready;

    // Credit check: a slot must be guaranteed free by the time the ALU answers.
    assign occupancy = {1'b0, res_count} + {2'b0, inflight} - {2'b0, pop_res};
    assign issue     = !fifo_empty && (occupancy < 3'(RES_BUF));

    assign count_after_pop = res_count - {1'b0, pop_res};
    assign captured        = '{op: inflight_op, y: alu_y, zf: alu_zf, of: alu_of, cf: alu_cf};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_op <= 3'd0;
            res_count   <= 2'd0;
            slot0       <= '0;
            slot1       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_op <= head.op;
            end
            if (pop_res) begin
                slot0 <= slot1;
            end
            // Capture lands in the first slot left free after this edge's pop.
            if (inflight) begin
                if (count_after_pop == 2'd0) begin
                    slot0 <= captured;
                end else begin
                    slot1 <= captured;
                end
            end
            res_count <= res_count + {1'b0, inflight} - {1'b0, pop_res};
        end
    end

    assign res_op = slot0.op;
    assign res_y  = slot0.y;
    assign res_zf = slot0.zf;
    assign res_of = slot0.of;
    assign res_cf = slot0.cf;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    // A delivery on the same edge as a clear keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_of <= 1'b0;
            sticky_cf <= 1'b0;
        end else begin
            sticky_of <= (pop_res && res_of) || (sticky_of && !sticky_clr);
            sticky_cf <= (pop_res && res_cf) || (sticky_cf && !sticky_clr);
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a registered 4-bit ALU model and result scoreboard.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int NV    = 11;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [2:0]             cmd_op = '0;
    logic [3:0]             cmd_a = '0;
    logic [3:0]             cmd_b = '0;
    logic [2:0]             alu_sel;
    logic [3:0]             alu_a;
    logic [3:0]             alu_b;
    logic [3:0]             alu_y = '0;
    logic                   alu_zf = 1'b0;
    logic                   alu_of = 1'b0;
    logic                   alu_cf = 1'b0;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [2:0]             res_op;
    logic [3:0]             res_y;
    logic                   res_zf;
    logic                   res_of;
    logic                   res_cf;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic                   sticky_clr = 1'b0;
    logic                   sticky_of;
    logic                   sticky_cf;
`endif

    alu_cmd_sequencer #(.DEPTH(DEPTH), .RES_BUF(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_sel    (alu_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_y      (alu_y),
        .alu_zf     (alu_zf),
        .alu_of     (alu_of),
        .alu_cf     (alu_cf),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_op     (res_op),
        .res_y      (res_y),
        .res_zf     (res_zf),
        .res_of     (res_of),
        .res_cf     (res_cf),
        .fifo_level (fifo_level)
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        ,
        .sticky_clr (sticky_clr),
        .sticky_of  (sticky_of),
        .sticky_cf  (sticky_cf)
`endif
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input logic [2:0] op, input logic [3:0] y,
                                input logic zf, input logic of, input logic cf);
        res_t r;
        r = '{op: op, y: y, zf: zf, of: of, cf: cf};
        return r;
    endfunction

    function automatic res_t ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        res_t       r;
        logic [4:0] s;
        r    = '0;
        s    = '0;
        r.op = op;
        case (op)
            ALU_OP_ADD: begin
                s    = {1'b0, a} + {1'b0, b};
                r.y  = s[3:0];
                r.cf = s[4];
                r.of = (a[3] == b[3]) && (r.y[3] != a[3]);
                r.zf = (r.y == 4'd0);
            end
            ALU_OP_SUB: begin
                s    = {1'b0, a} - {1'b0, b};
                r.y  = s[3:0];
                r.cf = s[4];
                r.of = (a[3] != b[3]) && (r.y[3] != a[3]);
                r.zf = (r.y == 4'd0);
            end
            ALU_OP_NOT: r.y = ~a;
            ALU_OP_AND: r.y = a & b;
            ALU_OP_OR:  r.y = a | b;
            ALU_OP_XOR: r.y = a ^ b;
            ALU_OP_LT:  r.y = {3'b000, ($signed(a) < $signed(b))};
            default:    r.y = {3'b000, (a == b)};
        endcase
        return r;
    endfunction

    // Registered ALU model: samples the select/operands every edge.
    res_t alu_next;
    always @(posedge clk) begin
        alu_next = ref_alu(alu_sel, alu_a, alu_b);
        alu_y  <= alu_next.y;
        alu_zf <= alu_next.zf;
        alu_of <= alu_next.of;
        alu_cf <= alu_next.cf;
    end

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   del_cnt = 0;
    int   del_cyc_q[$];
    res_t sb_q[$];
    res_t mon_act;
    res_t mon_exp;

    always @(negedge clk) begin
        cyc++;
        if (rst_n && res_valid && res_ready) begin
            mon_act = '{op: res_op, y: res_y, zf: res_zf, of: res_of, cf: res_cf};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected actual=%h required=none", mon_act);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_result actual=%h required=%h", mon_act, mon_exp);
                end
            end
            del_cnt++;
            del_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                            input res_t exp);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                sb_q.push_back(exp);
                @(posedge clk);
                #1;
                cmd_valid = 1'b0;
                return;
            end
        end
        cmd_valid = 1'b0;
        chk("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        res_t       exp;
    } vec_t;

    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0;
        int   accepted;
        res_t held;
        res_t now_res;

        vecs[0]  = '{ALU_OP_ADD, 4'h7, 4'h1, mk(ALU_OP_ADD, 4'h8, 1'b0, 1'b1, 1'b0)};
        vecs[1]  = '{ALU_OP_SUB, 4'h3, 4'h5, mk(ALU_OP_SUB, 4'hE, 1'b0, 1'b0, 1'b1)};
        vecs[2]  = '{ALU_OP_SUB, 4'h5, 4'h5, mk(ALU_OP_SUB, 4'h0, 1'b1, 1'b0, 1'b0)};
        vecs[3]  = '{ALU_OP_AND, 4'h8, 4'h1, mk(ALU_OP_AND, 4'h0, 1'b0, 1'b0, 1'b0)};
        vecs[4]  = '{ALU_OP_OR,  4'h8, 4'h1, mk(ALU_OP_OR,  4'h9, 1'b0, 1'b0, 1'b0)};
        vecs[5]  = '{ALU_OP_XOR, 4'h8, 4'h1, mk(ALU_OP_XOR, 4'h9, 1'b0, 1'b0, 1'b0)};
        vecs[6]  = '{ALU_OP_LT,  4'h8, 4'h1, mk(ALU_OP_LT,  4'h1, 1'b0, 1'b0, 1'b0)};
        vecs[7]  = '{ALU_OP_EQ,  4'h5, 4'h5, mk(ALU_OP_EQ,  4'h1, 1'b0, 1'b0, 1'b0)};
        vecs[8]  = '{ALU_OP_NOT, 4'h5, 4'h0, mk(ALU_OP_NOT, 4'hA, 1'b0, 1'b0, 1'b0)};
        vecs[9]  = '{ALU_OP_ADD, 4'hF, 4'h1, mk(ALU_OP_ADD, 4'h0, 1'b1, 1'b0, 1'b1)};
        vecs[10] = '{ALU_OP_ADD, 4'h4, 4'h4, mk(ALU_OP_ADD, 4'h8, 1'b0, 1'b1, 1'b0)};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_fields", 32'({res_op, res_y, res_zf, res_of, res_cf}), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_alu_drive", 32'({alu_sel, alu_a, alu_b}), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rel_res_valid", 32'(res_valid), 32'd0);

        // Minimum latency: accepted E0, result valid after E2
        res_ready = 1'b1;
        push_cmd(ALU_OP_ADD, 4'h7, 4'h1, mk(ALU_OP_ADD, 4'h8, 1'b0, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        chk("lat_after_e1", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_after_e2", 32'(res_valid), 32'd1);
        wait_drain(20);

        // Table vectors, back-to-back, full throughput
        del_cyc_q.delete();
        d0 = del_cnt;
        for (int i = 0; i < NV; i++) begin
            push_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end
        wait_drain(40);
        chk("tbl_count", 32'(del_cnt - d0), 32'(NV));
        if (del_cyc_q.size() == NV) begin
            chk("tbl_consecutive", 32'(del_cyc_q[NV-1] - del_cyc_q[0]), 32'(NV - 1));
        end else begin
            chk("tbl_deliveries", 32'(del_cyc_q.size()), 32'(NV));
        end

        // Backpressure: DEPTH+2 accepted then stall, outputs held
        res_ready = 1'b0;
        accepted  = 0;
        d0        = del_cnt;
        cmd_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cmd_op = 3'(accepted);
            cmd_a  = 4'(accepted * 3 + 1);
            cmd_b  = 4'(accepted + 5);
            @(negedge clk);
            if (cmd_ready) begin
                sb_q.push_back(ref_alu(cmd_op, cmd_a, cmd_b));
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'(DEPTH + 2));
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_fifo_level", 32'(fifo_level), 32'(DEPTH));
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        held = '{op: res_op, y: res_y, zf: res_zf, of: res_of, cf: res_cf};
        repeat (3) @(posedge clk);
        #1;
        now_res = '{op: res_op, y: res_y, zf: res_zf, of: res_of, cf: res_cf};
        chk("bp_held_stable", 32'(now_res), 32'(held));
        chk("bp_held_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        wait_drain(40);
        chk("bp_delivered", 32'(del_cnt - d0), 32'(DEPTH + 2));
        chk("bp_level_empty", 32'(fifo_level), 32'd0);

        // Reset mid-operation with a command in flight and results buffered
        res_ready = 1'b0;
        push_cmd(ALU_OP_ADD, 4'h1, 4'h2, ref_alu(ALU_OP_ADD, 4'h1, 4'h2));
        push_cmd(ALU_OP_SUB, 4'h9, 4'h3, ref_alu(ALU_OP_SUB, 4'h9, 4'h3));
        push_cmd(ALU_OP_XOR, 4'hC, 4'h5, ref_alu(ALU_OP_XOR, 4'hC, 4'h5));
        push_cmd(ALU_OP_OR,  4'h2, 4'h4, ref_alu(ALU_OP_OR,  4'h2, 4'h4));
        repeat (3) @(posedge clk);
        #1;
        chk("mid_level_pre", 32'(fifo_level), 32'd2);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_res_y", 32'(res_y), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        d0 = del_cnt;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_no_stale", 32'(del_cnt - d0), 32'd0);
        chk("post_rst_res_valid", 32'(res_valid), 32'd0);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        push_cmd(ALU_OP_ADD, 4'hF, 4'h1, mk(ALU_OP_ADD, 4'h0, 1'b1, 1'b0, 1'b1));
        wait_drain(20);
        chk("post_rst_one", 32'(del_cnt - d0), 32'd1);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        chk("sticky_cleared", 32'({sticky_of, sticky_cf}), 32'd0);
        push_cmd(ALU_OP_ADD, 4'h7, 4'h1, mk(ALU_OP_ADD, 4'h8, 1'b0, 1'b1, 1'b0));
        wait_drain(20);
        chk("sticky_of_set", 32'(sticky_of), 32'd1);
        chk("sticky_cf_clear", 32'(sticky_cf), 32'd0);
        sticky_clr = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        chk("sticky_of_clr", 32'(sticky_of), 32'd0);
        res_ready = 1'b0;
        push_cmd(ALU_OP_ADD, 4'h7, 4'h1, mk(ALU_OP_ADD, 4'h8, 1'b0, 1'b1, 1'b0));
        for (int n = 0; n < 10; n++) begin
            if (res_valid) break;
            @(posedge clk);
            #1;
        end
        chk("sticky_wait_valid", 32'(res_valid), 32'd1);
        chk("sticky_of_before", 32'(sticky_of), 32'd0);
        sticky_clr = 1'b1;
        res_ready  = 1'b1;
        @(posedge clk);
        #1 sticky_clr = 1'b0;
        chk("sticky_set_wins", 32'(sticky_of), 32'd1);
        wait_drain(20);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
